// File: rtl/fetch_buf_ctrl.sv
// Circular instruction-packet queue between fetch and the FIFO->ID register.
// First-word fall-through head; a NOP packet is presented when empty.
module fetch_buf_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fb_flush,
    input  logic             if_readygo,
    output logic             fb_allowin,
    input  logic [31:0]      if_inst0,
    input  logic [31:0]      if_inst1,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_pc_next,
    input  logic [31:0]      if_badv,
    input  logic [6:0]       if_exception,
    input  logic [1:0]       if_excp_flag,
    input  logic [1:0]       if_priv_flag,
    input  logic             fifo_allowin,
    output logic             fifo_readygo,
    output logic [31:0]      fifo_inst0,
    output logic [31:0]      fifo_inst1,
    output logic [31:0]      fifo_pc,
    output logic [31:0]      fifo_pcAdd,
    output logic [31:0]      fifo_pc_next,
    output logic [31:0]      fifo_badv,
    output logic [6:0]       fifo_exception,
    output logic [1:0]       fifo_excp_flag,
    output logic [1:0]       fifo_priv_flag,
    output logic             fetch_buf_empty,
    output logic             fetch_buf_full,
    output logic [PTR_W:0]   fb_count
);

    localparam logic [31:0]      INST_NOP = 32'h03400000;
    localparam logic [31:0]      PC_RESET = 32'h1c000000;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // HOLD: an excepting packet was accepted; fetch stays blocked until flush.
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
        logic [1:0]  priv_flag;
    } pkt_t;

    pkt_t             mem_q [DEPTH];
    pkt_t             wr_pkt;
    pkt_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    logic             empty, full, enq, deq;

    always_comb begin
        wr_pkt.inst0     = if_inst0;
        wr_pkt.inst1     = if_inst1;
        wr_pkt.pc        = if_pc;
        wr_pkt.pc_next   = if_pc_next;
        wr_pkt.badv      = if_badv;
        wr_pkt.exception = if_exception;
        wr_pkt.excp_flag = if_excp_flag;
        wr_pkt.priv_flag = if_priv_flag;
        head             = mem_q[rd_ptr_q];
    end

    assign empty           = (count_q == '0);
    assign full            = (count_q == CNT_FULL);
    assign fifo_readygo    = ~empty;
    assign deq             = fifo_readygo & fifo_allowin;
    assign fb_allowin      = (state_q == RUN) & (~full | fifo_allowin);
    assign enq             = if_readygo & fb_allowin & ~fb_flush;
    assign fetch_buf_empty = empty;
    assign fetch_buf_full  = full;
    assign fb_count        = count_q;

    always_comb begin
        if (empty) begin
            fifo_inst0     = INST_NOP;
            fifo_inst1     = INST_NOP;
            fifo_pc        = PC_RESET;
            fifo_pcAdd     = PC_RESET + 32'd4;
            fifo_pc_next   = PC_RESET + 32'd8;
            fifo_badv      = PC_RESET;
            fifo_exception = '0;
            fifo_excp_flag = '0;
            fifo_priv_flag = '0;
        end else begin
            fifo_inst0     = head.inst0;
            fifo_inst1     = head.inst1;
            fifo_pc        = head.pc;
            fifo_pcAdd     = head.pc + 32'd4;
            fifo_pc_next   = head.pc_next;
            fifo_badv      = head.badv;
            fifo_exception = head.exception;
            fifo_excp_flag = head.excp_flag;
            fifo_priv_flag = head.priv_flag;
        end
    end

    // Flush drops the same-cycle enqueue; the dequeue is already consumed downstream.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (fb_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (state_q == RUN && enq && if_excp_flag != 2'b00) state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= wr_pkt;
    end

endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// Bench for fetch_buf_ctrl: queue-based reference model, driver pushes accepted
// packets, monitor compares the presented head and occupancy every cycle.
module tb_fetch_buf_ctrl;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int W     = 171;

    typedef struct packed {
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp;
        logic [1:0]  priv;
    } pkt_t;

    logic clk = 1'b0;
    logic rstn, fb_flush, if_readygo, fb_allowin, fifo_allowin, fifo_readygo;
    logic [31:0] if_inst0, if_inst1, if_pc, if_pc_next, if_badv;
    logic [6:0]  if_exception;
    logic [1:0]  if_excp_flag, if_priv_flag;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag, fifo_priv_flag;
    logic        fetch_buf_empty, fetch_buf_full;
    logic [PTR_W:0] fb_count;

    logic [W-1:0] exp_q[$];
    bit  hold   = 1'b0;
    bit  mon_en = 1'b0;
    int  total  = 0;
    int  bad    = 0;

    fetch_buf_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rstn(rstn), .fb_flush(fb_flush), .if_readygo(if_readygo),
        .fb_allowin(fb_allowin), .if_inst0(if_inst0), .if_inst1(if_inst1),
        .if_pc(if_pc), .if_pc_next(if_pc_next), .if_badv(if_badv),
        .if_exception(if_exception), .if_excp_flag(if_excp_flag),
        .if_priv_flag(if_priv_flag), .fifo_allowin(fifo_allowin),
        .fifo_readygo(fifo_readygo), .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
        .fifo_pc(fifo_pc), .fifo_pcAdd(fifo_pcAdd), .fifo_pc_next(fifo_pc_next),
        .fifo_badv(fifo_badv), .fifo_exception(fifo_exception),
        .fifo_excp_flag(fifo_excp_flag), .fifo_priv_flag(fifo_priv_flag),
        .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full),
        .fb_count(fb_count)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic pkt_t mk_pkt(input logic [31:0] pc, input logic [1:0] excp);
        pkt_t p;
        p.inst0     = $urandom;
        p.inst1     = $urandom;
        p.pc        = pc;
        p.pc_next   = pc + 32'd8;
        p.badv      = $urandom;
        p.exception = 7'($urandom_range(0, 127));
        p.excp      = excp;
        p.priv      = 2'($urandom_range(0, 3));
        return p;
    endfunction

    // Driver: one cycle of stimulus; the model decides acceptance from its own state.
    task automatic drive(input bit rdy, input pkt_t p, input bit alw, input bit fl, input bit rn);
        bit acc;
        @(negedge clk);
        rstn         = rn;
        fb_flush     = fl;
        if_readygo   = rdy;
        fifo_allowin = alw;
        if_inst0     = p.inst0;
        if_inst1     = p.inst1;
        if_pc        = p.pc;
        if_pc_next   = p.pc_next;
        if_badv      = p.badv;
        if_exception = p.exception;
        if_excp_flag = p.excp;
        if_priv_flag = p.priv;
        #1;
        acc = rdy && !hold && !fl && (exp_q.size() < DEPTH || alw);
        #2;
        if (!rn || fl) begin
            exp_q.delete();
            hold = 1'b0;
        end else if (acc) begin
            exp_q.push_back(W'(p));
            if (p.excp != 2'b00) hold = 1'b1;
        end
    endtask

    task automatic idle(input bit alw, input int n);
        pkt_t z;
        z = '0;
        for (int i = 0; i < n; i++) drive(1'b0, z, alw, 1'b0, 1'b1);
    endtask

    // Monitor: compares what the DUT presents against the model once per cycle.
    initial begin
        pkt_t h;
        int   sz;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                sz = exp_q.size();
                chk("count", 32'(fb_count), 32'(sz));
                chk("empty", 32'(fetch_buf_empty), 32'(sz == 0));
                chk("full", 32'(fetch_buf_full), 32'(sz == DEPTH));
                chk("readygo", 32'(fifo_readygo), 32'(sz != 0));
                chk("allowin", 32'(fb_allowin), 32'(!hold && (sz < DEPTH || fifo_allowin)));
                if (sz > 0) begin
                    h = pkt_t'(exp_q[0]);
                    chk("inst0", fifo_inst0, h.inst0);
                    chk("inst1", fifo_inst1, h.inst1);
                    chk("pc", fifo_pc, h.pc);
                    chk("pcAdd", fifo_pcAdd, h.pc + 32'd4);
                    chk("pc_next", fifo_pc_next, h.pc_next);
                    chk("badv", fifo_badv, h.badv);
                    chk("exception", 32'(fifo_exception), 32'(h.exception));
                    chk("excp_flag", 32'(fifo_excp_flag), 32'(h.excp));
                    chk("priv_flag", 32'(fifo_priv_flag), 32'(h.priv));
                    if (fifo_allowin) void'(exp_q.pop_front());
                end else begin
                    chk("nop_inst0", fifo_inst0, 32'h03400000);
                    chk("nop_inst1", fifo_inst1, 32'h03400000);
                    chk("nop_pc", fifo_pc, 32'h1c000000);
                    chk("nop_pcAdd", fifo_pcAdd, 32'h1c000004);
                    chk("nop_pc_next", fifo_pc_next, 32'h1c000008);
                    chk("nop_badv", fifo_badv, 32'h1c000000);
                    chk("nop_flags", {23'd0, fifo_exception, fifo_excp_flag}, 32'd0);
                    chk("nop_priv", 32'(fifo_priv_flag), 32'd0);
                end
            end
        end
    end

    initial begin
        pkt_t z;
        z = '0;
        rstn = 1'b0; fb_flush = 1'b0; if_readygo = 1'b0; fifo_allowin = 1'b0;
        if_inst0 = '0; if_inst1 = '0; if_pc = '0; if_pc_next = '0; if_badv = '0;
        if_exception = '0; if_excp_flag = '0; if_priv_flag = '0;
        drive(1'b0, z, 1'b0, 1'b0, 1'b0);
        drive(1'b0, z, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        // In-order drain after three buffered packets
        for (int i = 0; i < 3; i++) drive(1'b1, mk_pkt(32'h1c000000 + 32'(i * 8), 2'b00), 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        idle(1'b1, 4);

        // Fill to full, then simultaneous enqueue/dequeue across the wrap
        for (int i = 0; i < DEPTH; i++) drive(1'b1, mk_pkt(32'h2000_0000 + 32'(i * 8), 2'b00), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h2000_1000, 2'b00), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, mk_pkt(32'h3000_0000 + 32'(i * 8), 2'b00), 1'b1, 1'b0, 1'b1);
        idle(1'b1, DEPTH + 2);

        // Excepting packet blocks fetch until flush
        drive(1'b1, mk_pkt(32'h4000_0000, 2'b01), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h4000_0008, 2'b00), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h4000_0010, 2'b00), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h4000_0018, 2'b00), 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);
        drive(1'b0, z, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1);

        // Flush with offer and dequeue in the same cycle
        for (int i = 0; i < 5; i++) drive(1'b1, mk_pkt(32'h5000_0000 + 32'(i * 8), 2'b00), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h5000_1000, 2'b00), 1'b1, 1'b1, 1'b1);
        idle(1'b0, 2);

        // Reset mid-operation while holding
        for (int i = 0; i < 3; i++) drive(1'b1, mk_pkt(32'h6000_0000 + 32'(i * 8), 2'b00), 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk_pkt(32'h6000_0018, 2'b10), 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        drive(1'b0, z, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);

        // pcAdd wraps around 2^32
        drive(1'b1, mk_pkt(32'hfffffffc, 2'b00), 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0,
                  mk_pkt($urandom & 32'hffff_fffc, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 199) != 0);
        end
        idle(1'b1, DEPTH + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
